// File: rtl/i_execute_pkg.sv
// Shared definitions for the MIPS execute stage: ALU control codes,
// funct field values, ALU op classes from the control unit, and the bit
// positions of the WB and M control bundles carried through ID/EX and EX/MEM.
package i_execute_pkg;

    // 4-bit ALU control codes seen by the ALU
    typedef enum logic [3:0] {
        ALU_AND = 4'b0000,
        ALU_OR  = 4'b0001,
        ALU_ADD = 4'b0010,
        ALU_SUB = 4'b0110,
        ALU_SLT = 4'b0111,
        ALU_NOR = 4'b1100
    } alu_ctl_e;

    // ALU op class produced by the main control unit
    typedef enum logic [1:0] {
        ALU_OP_ADD   = 2'b00,
        ALU_OP_SUB   = 2'b01,
        ALU_OP_FUNCT = 2'b10,
        ALU_OP_RSVD  = 2'b11
    } alu_op_e;

    // R-type funct field values that the ALU control understands
    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;
    localparam logic [5:0] FUNCT_NOR = 6'b100111;

    // Bit positions inside the WB control bundle
    localparam int WB_REG_WRITE  = 1;
    localparam int WB_MEM_TO_REG = 0;

    // Bit positions inside the M control bundle
    localparam int M_BRANCH    = 2;
    localparam int M_MEM_READ  = 1;
    localparam int M_MEM_WRITE = 0;

endpackage

// File: rtl/i_execute_alu.sv
// Purely combinational ALU for the execute stage. Add and subtract wrap
// modulo 2^WIDTH with no overflow trap; SLT is a signed compare whose
// single-bit answer is zero-extended to the full width.
module alu
    import i_execute_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       ctl,
    output logic [WIDTH-1:0] result,
    output logic             zero
);

    logic less_than;

    // Signed compare used only by SLT
    always_comb begin
        less_than = $signed(a) < $signed(b);
    end

    // Select the operation; unknown codes fall back to add
    always_comb begin
        result = a + b;
        case (ctl)
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_ADD: result = a + b;
            ALU_SUB: result = a - b;
            ALU_SLT: result = {{(WIDTH-1){1'b0}}, less_than};
            ALU_NOR: result = ~(a | b);
            default: result = a + b;
        endcase
    end

    // Zero flag is taken from the unregistered result
    always_comb begin
        zero = (result == '0);
    end

endmodule

// File: rtl/i_execute.sv
// Execute stage of the 5-stage MIPS pipeline. Decodes the ALU control code,
// picks operand B and the destination register, runs the ALU, forms the
// branch target, and captures everything in the EX/MEM register, which
// supports a hold (stall) and a bubble load (flush).
module i_execute
    import i_execute_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall,
    input  logic                  flush,
    input  logic [1:0]            wb_ctl,
    input  logic [2:0]            m_ctl,
    input  logic                  reg_dst,
    input  logic                  alu_src,
    input  logic [1:0]            alu_op,
    input  logic [WIDTH-1:0]      npc,
    input  logic [WIDTH-1:0]      r_data1,
    input  logic [WIDTH-1:0]      r_data2,
    input  logic [WIDTH-1:0]      sign_ext,
    input  logic [REG_ADDR_W-1:0] instr_2016,
    input  logic [REG_ADDR_W-1:0] instr_1511,
    output logic [1:0]            wb_ctl_out,
    output logic                  branch,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [WIDTH-1:0]      add_result,
    output logic                  zero,
    output logic [WIDTH-1:0]      alu_result,
    output logic [WIDTH-1:0]      r_data2_out,
    output logic [REG_ADDR_W-1:0] write_reg
);

    logic [5:0]            funct;
    alu_ctl_e              alu_ctl;
    logic [WIDTH-1:0]      operand_b;
    logic [WIDTH-1:0]      ex_result;
    logic                  ex_zero;
    logic [WIDTH-1:0]      branch_target;
    logic [REG_ADDR_W-1:0] dest_reg;

    assign funct = sign_ext[5:0];

    // ALU control: op class from control unit, funct refines R-type ops
    always_comb begin
        alu_ctl = ALU_ADD;
        case (alu_op_e'(alu_op))
            ALU_OP_ADD: alu_ctl = ALU_ADD;
            ALU_OP_SUB: alu_ctl = ALU_SUB;
            ALU_OP_FUNCT: begin
                case (funct)
                    FUNCT_ADD: alu_ctl = ALU_ADD;
                    FUNCT_SUB: alu_ctl = ALU_SUB;
                    FUNCT_AND: alu_ctl = ALU_AND;
                    FUNCT_OR:  alu_ctl = ALU_OR;
                    FUNCT_SLT: alu_ctl = ALU_SLT;
                    FUNCT_NOR: alu_ctl = ALU_NOR;
                    default:   alu_ctl = ALU_ADD;
                endcase
            end
            default: alu_ctl = ALU_ADD;
        endcase
    end

    // Operand B is the immediate for I-type ops, rt otherwise
    always_comb begin
        operand_b = alu_src ? sign_ext : r_data2;
    end

    // Branch target is word-aligned offset from PC+4, wrapping silently
    always_comb begin
        branch_target = npc + (sign_ext << 2);
    end

    // Destination is rd for R-type, rt for loads and immediates
    always_comb begin
        dest_reg = reg_dst ? instr_1511 : instr_2016;
    end

    alu #(
        .WIDTH (WIDTH)
    ) u_alu (
        .a      (r_data1),
        .b      (operand_b),
        .ctl    (alu_ctl),
        .result (ex_result),
        .zero   (ex_zero)
    );

    // EX/MEM register: reset and flush load a bubble, stall holds
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_ctl_out  <= '0;
            branch      <= 1'b0;
            mem_read    <= 1'b0;
            mem_write   <= 1'b0;
            add_result  <= '0;
            zero        <= 1'b0;
            alu_result  <= '0;
            r_data2_out <= '0;
            write_reg   <= '0;
        end else if (flush) begin
            wb_ctl_out  <= '0;
            branch      <= 1'b0;
            mem_read    <= 1'b0;
            mem_write   <= 1'b0;
            add_result  <= '0;
            zero        <= 1'b0;
            alu_result  <= '0;
            r_data2_out <= '0;
            write_reg   <= '0;
        end else if (!stall) begin
            wb_ctl_out  <= wb_ctl;
            branch      <= m_ctl[M_BRANCH];
            mem_read    <= m_ctl[M_MEM_READ];
            mem_write   <= m_ctl[M_MEM_WRITE];
            add_result  <= branch_target;
            zero        <= ex_zero;
            alu_result  <= ex_result;
            r_data2_out <= r_data2;
            write_reg   <= dest_reg;
        end
    end

endmodule

// File: tb/tb_i_execute.sv
// Self-checking bench for the execute stage: directed scenarios with literal
// expectations, then randomized traffic compared every cycle against a
// behavioural model of the EX/MEM register contents.
module tb_i_execute;

    localparam int WIDTH = 32;
    localparam int RW    = 5;
    localparam int RANDOM_CYCLES = 600;

    logic            clk = 1'b0;
    logic            rst, stall, flush;
    logic [1:0]      wb_ctl;
    logic [2:0]      m_ctl;
    logic            reg_dst, alu_src;
    logic [1:0]      alu_op;
    logic [WIDTH-1:0] npc, r_data1, r_data2, sign_ext;
    logic [RW-1:0]   instr_2016, instr_1511;
    logic [1:0]      wb_ctl_out;
    logic            branch, mem_read, mem_write, zero;
    logic [WIDTH-1:0] add_result, alu_result, r_data2_out;
    logic [RW-1:0]   write_reg;

    // Model of what EX/MEM must hold
    logic [1:0]       expWb;
    logic [2:0]       expM;
    logic [WIDTH-1:0] expAdd, expAlu, expRd2;
    logic             expZero;
    logic [RW-1:0]    expWr;

    int  checkCount = 0;
    int  passCount  = 0;
    bit  checkEnable = 1'b0;

    always #5 clk = ~clk;

    i_execute #(
        .WIDTH      (WIDTH),
        .REG_ADDR_W (RW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .flush       (flush),
        .wb_ctl      (wb_ctl),
        .m_ctl       (m_ctl),
        .reg_dst     (reg_dst),
        .alu_src     (alu_src),
        .alu_op      (alu_op),
        .npc         (npc),
        .r_data1     (r_data1),
        .r_data2     (r_data2),
        .sign_ext    (sign_ext),
        .instr_2016  (instr_2016),
        .instr_1511  (instr_1511),
        .wb_ctl_out  (wb_ctl_out),
        .branch      (branch),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .add_result  (add_result),
        .zero        (zero),
        .alu_result  (alu_result),
        .r_data2_out (r_data2_out),
        .write_reg   (write_reg)
    );

    // Reference ALU written straight from the instruction semantics
    function automatic logic [WIDTH-1:0] refAlu(input logic [1:0] op, input logic [5:0] fn,
                                                input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        if (op == 2'b01) return a - b;
        if (op != 2'b10) return a + b;
        case (fn)
            6'h22:   return a - b;
            6'h24:   return a & b;
            6'h25:   return a | b;
            6'h27:   return ~(a | b);
            6'h2A:   return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: return a + b;
        endcase
    endfunction

    // Model update at each edge from the inputs present at that edge
    always @(posedge clk) begin
        logic [WIDTH-1:0] b;
        if (rst || flush) begin
            expWb = 0; expM = 0; expAdd = 0; expAlu = 0; expRd2 = 0; expZero = 0; expWr = 0;
        end else if (!stall) begin
            b       = alu_src ? sign_ext : r_data2;
            expAlu  = refAlu(alu_op, sign_ext[5:0], r_data1, b);
            expZero = (expAlu == 0);
            expAdd  = npc + sign_ext * 4;
            expWb   = wb_ctl;
            expM    = m_ctl;
            expRd2  = r_data2;
            expWr   = reg_dst ? instr_1511 : instr_2016;
        end
    end

    // Compare every DUT output against the model
    task automatic checkOutput();
        checkCount++;
        if (wb_ctl_out === expWb && {branch, mem_read, mem_write} === expM &&
            add_result === expAdd && zero === expZero && alu_result === expAlu &&
            r_data2_out === expRd2 && write_reg === expWr) begin
            passCount++;
        end else begin
            $display("[TB] FAIL cycle_compare t=%0t got wb=%b m=%b add=%h z=%b alu=%h rd2=%h wr=%0d exp wb=%b m=%b add=%h z=%b alu=%h rd2=%h wr=%0d",
                     $time, wb_ctl_out, {branch, mem_read, mem_write}, add_result, zero, alu_result,
                     r_data2_out, write_reg, expWb, expM, expAdd, expZero, expAlu, expRd2, expWr);
        end
    endtask

    // Literal expectation check
    task automatic checkValue(input string name, input logic [WIDTH-1:0] actual, input logic [WIDTH-1:0] expected);
        checkCount++;
        if (actual === expected) passCount++;
        else $display("[TB] FAIL %s got %h expected %h", name, actual, expected);
    endtask

    always @(negedge clk) begin
        if (checkEnable) checkOutput();
    end

    // Hold the given inputs across one rising edge
    task automatic applyStimulus(input logic r, input logic s, input logic f);
        rst = r; stall = s; flush = f;
        @(posedge clk);
        #1;
    endtask

    task automatic clearInputs();
        wb_ctl = 0; m_ctl = 0; reg_dst = 0; alu_src = 0; alu_op = 0;
        npc = 0; r_data1 = 0; r_data2 = 0; sign_ext = 0; instr_2016 = 0; instr_1511 = 0;
    endtask

    task automatic randomInputs();
        logic [5:0]       functs [7] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h27, 6'h00};
        logic [WIDTH-1:0] rnd;
        wb_ctl     = 2'($urandom_range(3));
        m_ctl      = 3'($urandom_range(7));
        reg_dst    = 1'($urandom_range(1));
        alu_src    = 1'($urandom_range(1));
        alu_op     = 2'($urandom_range(3));
        npc        = $urandom();
        r_data1    = ($urandom_range(3) == 0) ? 32'($urandom_range(8)) : $urandom();
        r_data2    = ($urandom_range(3) == 0) ? r_data1 : $urandom();
        rnd        = $urandom();
        sign_ext   = {rnd[31:6], functs[$urandom_range(6)]};
        if ($urandom_range(3) == 0) sign_ext = {{16{rnd[15]}}, rnd[15:6], sign_ext[5:0]};
        instr_2016 = RW'($urandom_range(31));
        instr_1511 = RW'($urandom_range(31));
    endtask

    initial begin
        clearInputs();
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkEnable = 1'b1;
        checkValue("reset_alu", alu_result, 0);
        checkValue("reset_wb", {30'd0, wb_ctl_out}, 0);

        // R-type add
        alu_op = 2'b10; sign_ext = 32'h20; r_data1 = 5; r_data2 = 7; alu_src = 0;
        reg_dst = 1; instr_1511 = 3;
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkValue("radd_alu", alu_result, 12);
        checkValue("radd_zero", {31'd0, zero}, 0);
        checkValue("radd_wr", {27'd0, write_reg}, 3);
        checkValue("model_radd", expAlu, 12);

        // beq with equal operands
        clearInputs();
        alu_op = 2'b01; r_data1 = 32'h1234; r_data2 = 32'h1234; npc = 32'h100;
        sign_ext = 32'hFFFF_FFFF; m_ctl = 3'b100;
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkValue("beq_alu", alu_result, 0);
        checkValue("beq_zero", {31'd0, zero}, 1);
        checkValue("beq_target", add_result, 32'hFC);
        checkValue("beq_branch", {31'd0, branch}, 1);
        checkValue("model_beq_target", expAdd, 32'hFC);

        // signed SLT, then swapped operands
        clearInputs();
        alu_op = 2'b10; sign_ext = 32'h2A; r_data1 = 32'hFFFF_FFFF; r_data2 = 1;
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkValue("slt_neg", alu_result, 1);
        r_data1 = 1; r_data2 = 32'hFFFF_FFFF;
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkValue("slt_swap", alu_result, 0);
        checkValue("model_slt_swap", expAlu, 0);

        // lw-style address computation
        clearInputs();
        alu_op = 2'b00; alu_src = 1; r_data1 = 32'h1000; r_data2 = 32'hDEAD; sign_ext = 32'h10;
        reg_dst = 0; instr_2016 = 8; instr_1511 = 17; m_ctl = 3'b010; wb_ctl = 2'b11;
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkValue("lw_alu", alu_result, 32'h1010);
        checkValue("lw_wr", {27'd0, write_reg}, 8);
        checkValue("lw_memread", {31'd0, mem_read}, 1);
        checkValue("lw_wb", {30'd0, wb_ctl_out}, 3);
        checkValue("lw_rd2", r_data2_out, 32'hDEAD);

        // stall two cycles with changed inputs
        for (int i = 0; i < 2; i++) begin
            randomInputs();
            applyStimulus(1'b0, 1'b1, 1'b0);
            checkValue("stall_alu", alu_result, 32'h1010);
            checkValue("stall_wr", {27'd0, write_reg}, 8);
        end

        // stall and flush together gives a bubble
        applyStimulus(1'b0, 1'b1, 1'b1);
        checkValue("flush_alu", alu_result, 0);
        checkValue("flush_ctl", {27'd0, wb_ctl_out, branch, mem_read, mem_write}, 0);

        // reset mid-stream overrides stall, then normal load resumes
        randomInputs();
        applyStimulus(1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0);
        checkValue("rst_alu", alu_result, 0);
        checkValue("rst_add", add_result, 0);
        clearInputs();
        alu_op = 2'b10; sign_ext = 32'h27; r_data1 = 32'h0F0F_0000; r_data2 = 32'h0000_00F0;
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkValue("after_rst_nor", alu_result, 32'hF0F0_FF0F);

        // randomized traffic with occasional control events
        for (int i = 0; i < RANDOM_CYCLES; i++) begin
            randomInputs();
            applyStimulus(($urandom_range(39) == 0), ($urandom_range(5) == 0), ($urandom_range(15) == 0));
        end

        @(negedge clk);
        #1;
        checkEnable = 1'b0;
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/i_execute.md
Name: i_execute

Overview:
Execute stage of the 5-stage MIPS pipeline, directly downstream of the decode stage's ID/EX register. It consumes ID/EX control and data, and performs:
- ALU control decode
- operand selection
- ALU operation
- branch-target add
- destination-register select

Results are latched into the EX/MEM pipeline register, which feeds the memory stage. The register supports hold (stall) and bubble insertion (flush).

Parameters:
WIDTH, 32, datapath width for operands, results and PC values
REG_ADDR_W, 5, register-file address width

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous, active-high reset
stall  in  1  hold EX/MEM contents this cycle
flush  in  1  load a bubble into EX/MEM this cycle
wb_ctl  in  2  ID/EX WB controls: [1] reg_write, [0] mem_to_reg
m_ctl  in  3  ID/EX M controls: [2] branch, [1] mem_read, [0] mem_write
reg_dst  in  1  1 selects instr_1511 as destination, 0 selects instr_2016
alu_src  in  1  1 selects sign_ext as operand B, 0 selects r_data2
alu_op  in  2  ALU op class from the control unit
npc  in  WIDTH  PC+4 of the instruction
r_data1  in  WIDTH  rs value
r_data2  in  WIDTH  rt value
sign_ext  in  WIDTH  sign-extended immediate; bits [5:0] are funct
instr_2016  in  REG_ADDR_W  rt field
instr_1511  in  REG_ADDR_W  rd field
wb_ctl_out  out  2  latched WB controls
branch  out  1  latched m_ctl[2]
mem_read  out  1  latched m_ctl[1]
mem_write  out  1  latched m_ctl[0]
add_result  out  WIDTH  latched branch target
zero  out  1  latched ALU-result-equals-zero flag
alu_result  out  WIDTH  latched ALU result
r_data2_out  out  WIDTH  latched rt value (store data)
write_reg  out  REG_ADDR_W  latched destination register

Behaviour:
- Latency: exactly one cycle. Combinational EX logic is captured at the rising clk edge; all outputs come straight from flops.
- Priority per edge: rst > flush > stall > normal load.
- rst: every output is 0 on the next edge, including wb_ctl_out, the memory controls, zero, add_result, alu_result, r_data2_out and write_reg.
- flush: every output is 0 on the next edge (bubble), regardless of stall.
- stall, with no flush: all outputs hold their previous values. Inputs are ignored.
- ALU control (4-bit code):
  - alu_op 00 -> ADD 0010
  - alu_op 01 -> SUB 0110
  - alu_op 10 -> decode funct:
    - 100000 -> ADD 0010
    - 100010 -> SUB 0110
    - 100100 -> AND 0000
    - 100101 -> OR 0001
    - 101010 -> SLT 0111
    - 100111 -> NOR 1100
    - any other funct -> 0010 (ADD)
  - alu_op 11 -> 0010 (ADD)
- Operands: A = r_data1; B = alu_src ? sign_ext : r_data2.
- ALU arithmetic:
  - ADD and SUB are modulo 2^WIDTH; carry and overflow are discarded and no trap is raised.
  - SLT is a signed two's-complement compare; the result is 1 or 0, zero-extended.
  - NOR = ~(A|B).
- zero = (ALU result == 0), computed before the register.
- Branch target: add_result = npc + (sign_ext << 2), modulo 2^WIDTH; wrap-around is silent.
- Destination: write_reg = reg_dst ? instr_1511 : instr_2016.
- Pass-through: r_data2_out takes r_data2 (never the muxed B); wb_ctl_out takes wb_ctl; branch/mem_read/mem_write take m_ctl[2]/[1]/[0].
- No internal state other than the EX/MEM flops. Deasserting rst mid-stream yields a clean bubble followed by normal operation on the next edge.

Decomposition:
- Shared package: ALU control codes (AND, OR, ADD, SUB, SLT, NOR), funct constants, alu_op encodings, and bit-index constants for the wb_ctl and m_ctl fields.
- One sub-module, alu: operands a and b, a 4-bit control input, and outputs result and zero; purely combinational.
- ALU control decode, the operand/destination muxes and the EX/MEM flops stay in i_execute.

Test Plan:
- R-type add: alu_op=10, funct=100000, r_data1=5, r_data2=7, alu_src=0, reg_dst=1, instr_1511=3 -> next edge: alu_result=12, zero=0, write_reg=3.
- Branch beq with equal operands: alu_op=01, r_data1=r_data2=0x1234, npc=0x100, sign_ext=0xFFFFFFFF, m_ctl=100 -> alu_result=0, zero=1, add_result=0xFC, branch=1.
- Signed SLT: funct=101010, r_data1=0xFFFFFFFF, r_data2=1 -> alu_result=1. Swapped operands -> alu_result=0.
- lw-style operation: alu_op=00, alu_src=1, r_data1=0x1000, sign_ext=0x10, reg_dst=0, instr_2016=8, m_ctl=010, wb_ctl=11 -> alu_result=0x1010, write_reg=8, mem_read=1, wb_ctl_out=11.
- Stall and flush: load an instruction, then assert stall for 2 cycles with changed inputs -> outputs unchanged. Then assert stall and flush together -> all outputs 0.
- Reset: assert rst mid-stream together with flush=0 and stall=1 -> all outputs 0 next edge. Deassert rst -> the next edge loads the current inputs normally.
